// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: owner state encoding and
// the constants used to record which requester won the last contested cycle.
package dm_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam logic [3:0] BURST_SAT = 4'd15;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundle of CPU, DMA and data-memory signals around the arbiter. The slave side
// is the arbiter; the master side is the requesters plus the memory itself.
interface dm_port_arbiter_if
  import dm_port_arbiter_pkg::*;
#(
  parameter int bit_size = 32,
  parameter int mem_size = 16
);

  logic                cpu_req;
  logic                cpu_we;
  logic [mem_size-1:0] cpu_addr;
  logic [bit_size-1:0] cpu_wdata;
  logic [bit_size-1:0] cpu_rdata;
  logic                cpu_stall;

  logic                dma_req;
  logic                dma_we;
  logic [mem_size-1:0] dma_addr;
  logic [bit_size-1:0] dma_wdata;
  logic [bit_size-1:0] dma_rdata;
  logic                dma_gnt;

  logic [mem_size-1:0] DM_Address;
  logic                DM_enable;
  logic [bit_size-1:0] DM_Write_Data;
  logic [bit_size-1:0] DM_Read_Data;

  // Current owner, exported for debug and coverage only.
  arb_state_t          owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_gnt,
    output DM_Address, DM_enable, DM_Write_Data,
    input  DM_Read_Data,
    output owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_gnt,
    input  DM_Address, DM_enable, DM_Write_Data,
    output DM_Read_Data,
    input  owner
  );

endinterface

// File: rtl/dm_port_arbiter_rr_pick2.sv
// Two-way round-robin picker with a DMA burst cap: combinational winner from the
// requests plus registered last-winner, burst count and owner state.
//
//   state   | meaning
//   --------+-------------------------------------------
//   ST_IDLE | nobody requested last cycle (or in reset)
//   ST_CPU  | CPU owned the memory last cycle
//   ST_DMA  | DMA owned the memory last cycle
module dm_port_arbiter_rr_pick2
  import dm_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_cpu,
  input  logic       req_dma,
  output logic       cpu_won,
  output logic       dma_won,
  output arb_state_t state
);

  localparam logic [3:0] BURST_CAP = 4'(MAX_BURST);

  logic       last_owner;
  logic [3:0] burst_cnt;

  always_comb begin
    cpu_won = 1'b0;
    dma_won = 1'b0;
    if (req_cpu && req_dma) begin
      // The cap only matters while the CPU is actually waiting.
      if (burst_cnt >= BURST_CAP)       cpu_won = 1'b1;
      else if (last_owner == OWN_CPU)   dma_won = 1'b1;
      else                              cpu_won = 1'b1;
    end else if (req_cpu) begin
      cpu_won = 1'b1;
    end else if (req_dma) begin
      dma_won = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_owner <= OWN_DMA;
      burst_cnt  <= 4'd0;
      state      <= ST_IDLE;
    end else begin
      if (req_cpu && req_dma) begin
        last_owner <= dma_won ? OWN_DMA : OWN_CPU;
        if (!dma_won)                   burst_cnt <= 4'd0;
        else if (burst_cnt != BURST_SAT) burst_cnt <= burst_cnt + 4'd1;
      end else if (req_dma) begin
        burst_cnt <= 4'd0;
      end

      if (cpu_won)      state <= ST_CPU;
      else if (dma_won) state <= ST_DMA;
      else              state <= ST_IDLE;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the CPU and the DMA engine; stalls
// the CPU while it is denied. Holds only the data muxes and stall/grant logic.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int bit_size  = 32,
  parameter int mem_size  = 16,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst,
  dm_port_arbiter_if.slave bus
);

  localparam logic [mem_size-1:0] ADDR_ZERO = '0;
  localparam logic [bit_size-1:0] DATA_ZERO = '0;

  logic pick_cpu;
  logic pick_dma;
  logic cpu_won;
  logic dma_won;

  dm_port_arbiter_rr_pick2 #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .req_cpu (bus.cpu_req),
    .req_dma (bus.dma_req),
    .cpu_won (pick_cpu),
    .dma_won (pick_dma),
    .state   (bus.owner)
  );

  // While in reset nothing is granted, so no partial write can reach memory.
  assign cpu_won = rst & pick_cpu;
  assign dma_won = rst & pick_dma;

  always_comb begin
    bus.DM_Address    = ADDR_ZERO;
    bus.DM_Write_Data = DATA_ZERO;
    bus.DM_enable     = 1'b0;
    bus.cpu_rdata     = DATA_ZERO;
    bus.dma_rdata     = DATA_ZERO;
    if (cpu_won) begin
      bus.DM_Address    = bus.cpu_addr;
      bus.DM_Write_Data = bus.cpu_wdata;
      bus.DM_enable     = bus.cpu_we;
      bus.cpu_rdata     = bus.DM_Read_Data;
    end else if (dma_won) begin
      bus.DM_Address    = bus.dma_addr;
      bus.DM_Write_Data = bus.dma_wdata;
      bus.DM_enable     = bus.dma_we;
      bus.dma_rdata     = bus.DM_Read_Data;
    end
  end

  assign bus.cpu_stall = rst & bus.cpu_req & ~cpu_won;
  assign bus.dma_gnt   = dma_won;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: a reference model predicts each cycle's
// outputs into a queue, and a negedge monitor compares them against the DUT.
module tb_dm_port_arbiter;

  localparam int MAXB = 4;

  typedef struct {
    logic        en;
    logic [15:0] addr;
    logic [31:0] wd;
    logic        stall;
    logic        gnt;
    logic [31:0] crd;
    logic [31:0] drd;
    logic [1:0]  own;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  dm_port_arbiter_if #(.bit_size(32), .mem_size(16)) bus ();

  dm_port_arbiter #(
    .bit_size  (32),
    .mem_size  (16),
    .MAX_BURST (MAXB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write at the clock edge.
  logic [31:0] dm_mem [0:65535];
  assign bus.DM_Read_Data = dm_mem[bus.DM_Address];
  always @(posedge clk) if (bus.DM_enable) dm_mem[bus.DM_Address] <= bus.DM_Write_Data;

  // Reference model state.
  logic [31:0] ref_mem [0:65535];
  bit          m_last_dma = 1'b1;
  int          m_burst    = 0;
  logic [1:0]  m_own      = 2'd0;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   stall_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("DM_enable",     {31'd0, bus.DM_enable}, {31'd0, e.en});
      chk("DM_Address",    {16'd0, bus.DM_Address}, {16'd0, e.addr});
      chk("DM_Write_Data", bus.DM_Write_Data, e.wd);
      chk("cpu_stall",     {31'd0, bus.cpu_stall}, {31'd0, e.stall});
      chk("dma_gnt",       {31'd0, bus.dma_gnt}, {31'd0, e.gnt});
      chk("cpu_rdata",     bus.cpu_rdata, e.crd);
      chk("dma_rdata",     bus.dma_rdata, e.drd);
      chk("owner",         {30'd0, bus.owner}, {30'd0, e.own});
      stall_run = bus.cpu_stall ? stall_run + 1 : 0;
      if (stall_run > 0) begin
        n_cmp++;
        if (stall_run > MAXB) begin
          n_err++;
          $display("FAIL stall_run at %0t: got %0d consecutive, limit %0d", $time, stall_run, MAXB);
        end
      end
    end
  end

  // One bus cycle: apply inputs after the edge, predict outputs, advance the model.
  task automatic step(input logic r, input logic cr, input logic cw, input logic [15:0] ca,
                      input logic [31:0] cd, input logic dr, input logic dw,
                      input logic [15:0] da, input logic [31:0] dd);
    exp_t e;
    bit   c_win, d_win;
    @(posedge clk);
    #1;
    rst = r;
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wdata = dd;

    c_win = 1'b0;
    d_win = 1'b0;
    if (r) begin
      if (cr && !dr)      c_win = 1'b1;
      else if (dr && !cr) d_win = 1'b1;
      else if (cr && dr) begin
        if (m_burst >= MAXB) c_win = 1'b1;
        else if (!m_last_dma) d_win = 1'b1;
        else c_win = 1'b1;
      end
    end

    e.en    = (c_win && cw) || (d_win && dw);
    e.addr  = c_win ? ca : (d_win ? da : 16'd0);
    e.wd    = c_win ? cd : (d_win ? dd : 32'd0);
    e.stall = r && cr && !c_win;
    e.gnt   = d_win;
    e.crd   = c_win ? ref_mem[ca] : 32'd0;
    e.drd   = d_win ? ref_mem[da] : 32'd0;
    e.own   = m_own;
    exp_q.push_back(e);

    if (!r) begin
      m_last_dma = 1'b1;
      m_burst    = 0;
      m_own      = 2'd0;
    end else begin
      if (cr && dr) begin
        m_last_dma = d_win;
        m_burst    = d_win ? ((m_burst < 15) ? m_burst + 1 : 15) : 0;
      end else if (dr) begin
        m_burst = 0;
      end
      m_own = c_win ? 2'd1 : (d_win ? 2'd2 : 2'd0);
      if (e.en) ref_mem[e.addr] = e.wd;
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dm_mem[i]  = 32'd0;
      ref_mem[i] = 32'd0;
    end
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;

    // Reset with both requesting, then continuous contention.
    repeat (2) step(1'b0, 1'b1, 1'b0, 16'd1, 32'd0, 1'b1, 1'b1, 16'd2, 32'h1111_1111);
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 1'b0, 16'(i), 32'd0, 1'b1, 1'b1, 16'(8 + i), 32'hA000_0000 + 32'(i));

    // CPU write then read-back.
    step(1'b1, 1'b1, 1'b1, 16'd5, 32'hDEADBEEF, 1'b0, 1'b0, 16'd0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 16'd5, 32'd0, 1'b0, 1'b0, 16'd0, 32'd0);

    // DMA-only burst, then the CPU joins.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b0, 16'd0, 32'd0, 1'b1, 1'b1, 16'(20 + i), 32'hB000_0000 + 32'(i));
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 1'b0, 16'(20 + i), 32'd0, 1'b1, 1'b0, 16'd5, 32'd0);

    // Reset on the third cycle of alternation.
    for (int i = 0; i < 6; i++)
      step((i == 2) ? 1'b0 : 1'b1, 1'b1, 1'b1, 16'd30, 32'hC0DE_0000 + 32'(i),
           1'b1, 1'b1, 16'd31, 32'hD0DE_0000 + 32'(i));

    // Idle stretch.
    repeat (10) step(1'b1, 1'b0, 1'b0, 16'd7, 32'hFFFF_FFFF, 1'b0, 1'b1, 16'd9, 32'hFFFF_FFFF);

    // Randomized traffic over a small address window.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) != 0),
           ($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom_range(0, 15)), $urandom);
    end

    step(1'b1, 1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 16'd0, 32'd0);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
